// File: rtl/game_master_pkg.sv
// Shared definitions for the torpedo game master: state encoding and the
// magazine size limit imposed by the 4-bit shots_left output.
package game_master_pkg;

    localparam logic [2:0] ST_START  = 3'd0;
    localparam logic [2:0] ST_AIM    = 3'd1;
    localparam logic [2:0] ST_SHOOT  = 3'd2;
    localparam logic [2:0] ST_RELOAD = 3'd3;
    localparam logic [2:0] ST_END    = 3'd4;

    typedef enum logic [2:0] {
        S_START  = ST_START,
        S_AIM    = ST_AIM,
        S_SHOOT  = ST_SHOOT,
        S_RELOAD = ST_RELOAD,
        S_END    = ST_END
    } state_t;

    // shots_left is 4 bits wide, so the magazine cannot exceed 15 torpedoes.
    localparam int MAX_SHOTS_LIMIT = 15;

endpackage

// File: rtl/game_score_counter.sv
// Saturating hit accumulator: adds the number of targets hit this cycle to
// the score and clamps at all ones instead of wrapping.
module game_score_counter #(
    parameter int N_TARGETS = 2,
    parameter int SCORE_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_TARGETS-1:0] hit,
    output logic [SCORE_W-1:0]   score
);

    localparam int CNT_W = $clog2(N_TARGETS + 1);
    localparam int SUM_W = SCORE_W + CNT_W;

    logic [CNT_W-1:0] hit_count;
    logic [SUM_W-1:0] sum;

    // Population count of the hit vector.
    always_comb begin
        hit_count = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            hit_count = hit_count + CNT_W'(hit[i]);
        end
    end

    assign sum = SUM_W'(score) + SUM_W'(hit_count);

    // Accumulate, saturating when the sum overflows the score width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score <= '0;
        end else if (|hit) begin
            if (|sum[SUM_W-1:SCORE_W]) begin
                score <= '1;
            end else begin
                score <= sum[SCORE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/game_master_fsm_multi.sv
// Torpedo game master for N_TARGETS targets with a limited magazine.
// Phases: START | AIM | SHOOT | RELOAD | END. All outputs are registered
// from the next state, so they are valid in the first cycle of each state.
// Optional feature macro: GAME_MASTER_SCORE_EN builds the score counter;
// without it score is tied to zero.
module game_master_fsm_multi
    import game_master_pkg::*;
#(
    parameter int N_TARGETS = 2,
    parameter int MAX_SHOTS = 3,
    parameter int SCORE_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 key,
    input  logic [N_TARGETS-1:0] target_within_screen,
    input  logic                 torpedo_within_screen,
    input  logic [N_TARGETS-1:0] collision,
    input  logic                 end_of_game_timer_running,
    output logic [N_TARGETS-1:0] target_write_xy,
    output logic [N_TARGETS-1:0] target_write_dxy,
    output logic [N_TARGETS-1:0] target_enable_update,
    output logic                 torpedo_write_xy,
    output logic                 torpedo_write_dxy,
    output logic                 torpedo_enable_update,
    output logic                 end_of_game_timer_start,
    output logic                 game_won,
    output logic [N_TARGETS-1:0] alive,
    output logic [3:0]           shots_left,
    output logic [SCORE_W-1:0]   score
);

    localparam int         SHOTS_CLAMP = (MAX_SHOTS > MAX_SHOTS_LIMIT) ? MAX_SHOTS_LIMIT : MAX_SHOTS;
    localparam logic [3:0] SHOTS_INIT  = SHOTS_CLAMP[3:0];

    state_t               state, state_nx;
    logic [N_TARGETS-1:0] hit, alive_nx;
    logic [N_TARGETS-1:0] t_wxy_nx, t_wdxy_nx, t_en_nx;
    logic                 p_wxy_nx, p_wdxy_nx, p_en_nx, t_start_nx, won_nx;
    logic [3:0]           shots_nx;
    logic                 escape;

    assign hit    = (state == S_SHOOT) ? (collision & alive) : '0;
    assign escape = |(alive & ~target_within_screen);

    // Next-state decision, then the registered outputs implied by that state.
    always_comb begin
        state_nx   = state;
        alive_nx   = alive;
        shots_nx   = shots_left;
        won_nx     = game_won;
        t_wxy_nx   = '0;
        t_wdxy_nx  = '0;
        t_en_nx    = '0;
        p_wxy_nx   = 1'b0;
        p_wdxy_nx  = 1'b0;
        p_en_nx    = 1'b0;
        t_start_nx = 1'b0;

        case (state)
            // Out of reset the START actions have not been issued yet, which
            // shows as a low torpedo_write_xy; hold START one cycle to issue them.
            S_START: state_nx = torpedo_write_xy ? S_AIM : S_START;
            S_AIM: begin
                if (escape) begin
                    state_nx = S_END;
                end else if (key) begin
                    state_nx = S_SHOOT;
                    shots_nx = shots_left - 4'd1;
                end
            end
            S_SHOOT: begin
                alive_nx = alive & ~hit;
                if (|hit) begin
                    state_nx = S_RELOAD;
                end else if (escape) begin
                    state_nx = S_END;
                end else if (!torpedo_within_screen) begin
                    state_nx = S_RELOAD;
                end
            end
            S_RELOAD: begin
                if (alive == '0) begin
                    state_nx = S_END;
                end else if (shots_left == 4'd0) begin
                    state_nx = S_END;
                end else begin
                    state_nx = S_AIM;
                end
            end
            S_END:   state_nx = end_of_game_timer_running ? S_END : S_START;
            default: state_nx = S_START;
        endcase

        case (state_nx)
            S_START: begin
                t_wxy_nx  = '1;
                t_wdxy_nx = '1;
                p_wxy_nx  = 1'b1;
                alive_nx  = '1;
                shots_nx  = SHOTS_INIT;
                won_nx    = 1'b0;
            end
            S_AIM:   t_en_nx = alive_nx;
            S_SHOOT: begin
                t_en_nx   = alive_nx;
                p_en_nx   = 1'b1;
                p_wdxy_nx = (state != S_SHOOT);
            end
            S_RELOAD: begin
                t_en_nx  = alive_nx;
                p_wxy_nx = 1'b1;
            end
            S_END: begin
                if (state != S_END) begin
                    t_start_nx = 1'b1;
                    won_nx     = (alive_nx == '0);
                end
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= S_START;
            alive                   <= '0;
            shots_left              <= '0;
            game_won                <= 1'b0;
            target_write_xy         <= '0;
            target_write_dxy        <= '0;
            target_enable_update    <= '0;
            torpedo_write_xy        <= 1'b0;
            torpedo_write_dxy       <= 1'b0;
            torpedo_enable_update   <= 1'b0;
            end_of_game_timer_start <= 1'b0;
        end else begin
            state                   <= state_nx;
            alive                   <= alive_nx;
            shots_left              <= shots_nx;
            game_won                <= won_nx;
            target_write_xy         <= t_wxy_nx;
            target_write_dxy        <= t_wdxy_nx;
            target_enable_update    <= t_en_nx;
            torpedo_write_xy        <= p_wxy_nx;
            torpedo_write_dxy       <= p_wdxy_nx;
            torpedo_enable_update   <= p_en_nx;
            end_of_game_timer_start <= t_start_nx;
        end
    end

`ifdef GAME_MASTER_SCORE_EN
    game_score_counter #(
        .N_TARGETS(N_TARGETS),
        .SCORE_W  (SCORE_W)
    ) u_score (
        .clk    (clk),
        .reset_n(reset_n),
        .hit    (hit),
        .score  (score)
    );
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_game_master_fsm_multi.sv
// Randomized bench for game_master_fsm_multi against a game-rule model.
module tb_game_master_fsm_multi;

    localparam int NT   = 2;
    localparam int MS   = 3;
    localparam int SW   = 2;
    localparam int SMAX = (1 << SW) - 1;

    localparam int PH_START  = 100;
    localparam int PH_AIM    = 101;
    localparam int PH_SHOOT  = 102;
    localparam int PH_RELOAD = 103;
    localparam int PH_END    = 104;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          key;
    logic [NT-1:0] target_within_screen;
    logic          torpedo_within_screen;
    logic [NT-1:0] collision;
    logic          end_of_game_timer_running;
    logic [NT-1:0] target_write_xy, target_write_dxy, target_enable_update;
    logic          torpedo_write_xy, torpedo_write_dxy, torpedo_enable_update;
    logic          end_of_game_timer_start, game_won;
    logic [NT-1:0] alive;
    logic [3:0]    shots_left;
    logic [SW-1:0] score;

    game_master_fsm_multi #(.N_TARGETS(NT), .MAX_SHOTS(MS), .SCORE_W(SW)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .key                      (key),
        .target_within_screen     (target_within_screen),
        .torpedo_within_screen    (torpedo_within_screen),
        .collision                (collision),
        .end_of_game_timer_running(end_of_game_timer_running),
        .target_write_xy          (target_write_xy),
        .target_write_dxy         (target_write_dxy),
        .target_enable_update     (target_enable_update),
        .torpedo_write_xy         (torpedo_write_xy),
        .torpedo_write_dxy        (torpedo_write_dxy),
        .torpedo_enable_update    (torpedo_enable_update),
        .end_of_game_timer_start  (end_of_game_timer_start),
        .game_won                 (game_won),
        .alive                    (alive),
        .shots_left               (shots_left),
        .score                    (score)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the game as seen at the outputs
    int  m_phase;
    bit  m_fresh;
    bit  m_alive [NT];
    int  m_shots, m_score, m_wins;
    bit  m_won;
    bit  e_twxy, e_twdxy, e_pwxy, e_pwdxy, e_pen, e_tstart;
    bit  e_ten [NT];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input bit v [NT]);
        logic [31:0] r = '0;
        for (int i = 0; i < NT; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [31:0] rep(input bit b);
        logic [31:0] r = '0;
        for (int i = 0; i < NT; i++) r[i] = b;
        return r;
    endfunction

    task automatic model_reset();
        m_phase = PH_START;
        m_fresh = 1'b1;
        m_shots = 0;
        m_score = 0;
        m_won   = 1'b0;
        for (int i = 0; i < NT; i++) begin
            m_alive[i] = 1'b0;
            e_ten[i]   = 1'b0;
        end
        e_twxy = 0; e_twdxy = 0; e_pwxy = 0; e_pwdxy = 0; e_pen = 0; e_tstart = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int  nph;
        int  hits;
        int  living;
        bit  escaped;
        nph     = m_phase;
        hits    = 0;
        escaped = 1'b0;
        for (int i = 0; i < NT; i++)
            if (m_alive[i] && !target_within_screen[i]) escaped = 1'b1;
        case (m_phase)
            PH_START: begin
                nph     = m_fresh ? PH_START : PH_AIM;
                m_fresh = 1'b0;
            end
            PH_AIM: begin
                if (escaped) nph = PH_END;
                else if (key) begin
                    nph = PH_SHOOT;
                    m_shots = m_shots - 1;
                end
            end
            PH_SHOOT: begin
                for (int i = 0; i < NT; i++)
                    if (m_alive[i] && collision[i]) begin
                        m_alive[i] = 1'b0;
                        hits++;
                    end
`ifdef GAME_MASTER_SCORE_EN
                m_score = (m_score + hits > SMAX) ? SMAX : m_score + hits;
`endif
                if (hits > 0) nph = PH_RELOAD;
                else if (escaped) nph = PH_END;
                else if (!torpedo_within_screen) nph = PH_RELOAD;
            end
            PH_RELOAD: begin
                living = 0;
                for (int i = 0; i < NT; i++) living += int'(m_alive[i]);
                if (living == 0 || m_shots == 0) nph = PH_END;
                else nph = PH_AIM;
            end
            default: if (!end_of_game_timer_running) nph = PH_START;
        endcase

        e_twxy = 0; e_twdxy = 0; e_pwxy = 0; e_pwdxy = 0; e_pen = 0; e_tstart = 0;
        for (int i = 0; i < NT; i++) e_ten[i] = 1'b0;
        if (nph == PH_START) begin
            e_twxy = 1; e_twdxy = 1; e_pwxy = 1;
            for (int i = 0; i < NT; i++) m_alive[i] = 1'b1;
            m_shots = MS;
            m_won   = 1'b0;
        end else if (nph == PH_END) begin
            if (m_phase != PH_END) begin
                e_tstart = 1;
                living = 0;
                for (int i = 0; i < NT; i++) living += int'(m_alive[i]);
                m_won = (living == 0);
                if (m_won) m_wins++;
            end
        end else begin
            for (int i = 0; i < NT; i++) e_ten[i] = m_alive[i];
            e_pen   = (nph == PH_SHOOT);
            e_pwdxy = (nph == PH_SHOOT) && (m_phase != PH_SHOOT);
            e_pwxy  = (nph == PH_RELOAD);
        end
        m_phase = nph;
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".target_write_xy"},  32'(target_write_xy),  rep(e_twxy));
        check({ctx, ".target_write_dxy"}, 32'(target_write_dxy), rep(e_twdxy));
        check({ctx, ".target_enable"},    32'(target_enable_update), pack(e_ten));
        check({ctx, ".torpedo_write_xy"}, 32'(torpedo_write_xy),  32'(e_pwxy));
        check({ctx, ".torpedo_write_dxy"},32'(torpedo_write_dxy), 32'(e_pwdxy));
        check({ctx, ".torpedo_enable"},   32'(torpedo_enable_update), 32'(e_pen));
        check({ctx, ".timer_start"},      32'(end_of_game_timer_start), 32'(e_tstart));
        check({ctx, ".game_won"},         32'(game_won),   32'(m_won));
        check({ctx, ".alive"},            32'(alive),      pack(m_alive));
        check({ctx, ".shots_left"},       32'(shots_left), 32'(m_shots));
        check({ctx, ".score"},            32'(score),      32'(m_score));
    endtask

    task automatic drive_random();
        key                       = ($urandom_range(0, 3) == 0);
        torpedo_within_screen     = ($urandom_range(0, 5) != 0);
        end_of_game_timer_running = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < NT; i++) begin
            target_within_screen[i] = ($urandom_range(0, 59) != 0);
            collision[i]            = ($urandom_range(0, 4) == 0);
        end
    endtask

    initial begin
        bit did_rst;
        did_rst = 1'b0;
        m_wins  = 0;
        reset_n = 1'b0;
        key = 0; torpedo_within_screen = 1; end_of_game_timer_running = 0;
        target_within_screen = '1; collision = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all("reset");
        reset_n = 1'b1;
        drive_random();
        model_step();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            compare_all("run");
            if (!did_rst && cyc > 1500 && m_phase == PH_SHOOT) begin
                did_rst = 1'b1;
                reset_n = 1'b0;
                #2;
                model_reset();
                compare_all("async_rst");
                @(negedge clk);
                compare_all("rst_held");
                reset_n = 1'b1;
            end
            drive_random();
            model_step();
        end

        check("reset_mid_shoot_seen", 32'(did_rst), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
